// File: rtl/uart_prog_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_prog_loader
// Purpose  : Receives a framed byte stream from a UART receiver, assembles
//            DATA_W-bit little-endian words and writes them to consecutive
//            memory addresses (memory port B). Verifies the length header,
//            an optional XOR checksum and an inter-byte timeout. The finish
//            flag releases the CPU only after a complete, valid image.
//
// Frame    : [N : 4 bytes LE] [N x DATA_W/8 payload bytes, LSB first]
//            [XOR of payload bytes, only when CHECKSUM_EN = 1]
//
// Ports    : clk           - system clock (cpuclk domain)
//            rst           - asynchronous active-high reset
//            rx_valid_i    - one-cycle strobe, rx_byte_i is valid
//            rx_byte_i     - received byte
//            start_i       - synchronous restart, abandons any load
//            uart_data_o   - assembled word for memory port B
//            uart_addr_o   - write address for uart_data_o
//            uart_we_o     - one-cycle write strobe
//            uart_finish_o - image loaded and verified (level)
//            load_error_o  - frame rejected (level)
//            word_count_o  - number of words written so far
//
// Revision : 1.0 - initial parametrised release
// ============================================================================
module uart_prog_loader #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                ADDR_STEP   = 4,
  parameter int                MAX_WORDS   = 16384,
  parameter int                CHECKSUM_EN = 1,
  parameter int                TIMEOUT     = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_byte_i,
  input  logic              start_i,
  output logic [DATA_W-1:0] uart_data_o,
  output logic [ADDR_W-1:0] uart_addr_o,
  output logic              uart_we_o,
  output logic              uart_finish_o,
  output logic              load_error_o,
  output logic [31:0]       word_count_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                c_BPW       = DATA_W / 8;
  localparam int                c_IDXW      = (c_BPW > 1) ? $clog2(c_BPW) : 1;
  localparam logic [ADDR_W-1:0] c_STEP      = ADDR_W'(ADDR_STEP);
  localparam logic [31:0]       c_MAX_WORDS = MAX_WORDS;
  localparam logic [31:0]       c_TIMEOUT   = TIMEOUT;

  localparam logic [2:0] c_ST_HDR     = 3'd0;
  localparam logic [2:0] c_ST_PAYLOAD = 3'd1;
  localparam logic [2:0] c_ST_CSUM    = 3'd2;
  localparam logic [2:0] c_ST_DONE    = 3'd3;
  localparam logic [2:0] c_ST_ERR     = 3'd4;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]        state_q,    state_d;
  logic [2:0]        hdr_cnt_q,  hdr_cnt_d;   // header bytes seen (0..3)
  logic [31:0]       len_q,      len_d;       // length header, shifted in LE
  logic [c_IDXW-1:0] byte_idx_q, byte_idx_d;  // byte position in current word
  logic [DATA_W-1:0] buf_q,      buf_d;       // word under assembly
  logic [7:0]        csum_q,     csum_d;      // running XOR of payload bytes
  logic [31:0]       asm_cnt_q,  asm_cnt_d;   // words fully assembled
  logic [31:0]       timer_q,    timer_d;     // idle cycles since last byte
  logic [DATA_W-1:0] data_q,     data_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic              we_q,       we_d;
  logic              finish_q,   finish_d;
  logic              err_q,      err_d;
  logic [31:0]       wcount_q,   wcount_d;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_word;        // buffer with the incoming byte inserted
  logic [31:0]       w_new_len;     // length value once the 4th byte lands
  logic              w_last_byte;   // incoming byte completes the word
  logic              w_last_word;   // word being completed is word N-1
  logic              w_timer_run;
  logic              w_timeout;

  always_comb begin
    w_word = buf_q;
    for (int k = 0; k < c_BPW; k++) begin
      if (int'(byte_idx_q) == k) begin
        w_word[8*k +: 8] = rx_byte_i;
      end
    end
  end

  assign w_new_len   = {rx_byte_i, len_q[31:8]};
  assign w_last_byte = (int'(byte_idx_q) == (c_BPW - 1));
  assign w_last_word = (asm_cnt_q == (len_q - 32'd1));

  // The timer is idle while waiting for the first header byte so the loader
  // can sit in HDR indefinitely until a host starts talking.
  assign w_timer_run = (c_TIMEOUT != 32'd0) &&
                       (((state_q == c_ST_HDR) && (hdr_cnt_q != 3'd0)) ||
                        (state_q == c_ST_PAYLOAD) ||
                        (state_q == c_ST_CSUM));
  assign w_timeout   = w_timer_run && !rx_valid_i &&
                       ((timer_q + 32'd1) == c_TIMEOUT);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    buf_d      = buf_q;
    csum_d     = csum_q;
    asm_cnt_d  = asm_cnt_q;
    timer_d    = timer_q;
    data_d     = data_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    finish_d   = finish_q;
    err_d      = err_q;
    wcount_d   = wcount_q;

    if (start_i) begin
      // Restart has priority over a coincident byte, which is dropped.
      state_d    = c_ST_HDR;
      hdr_cnt_d  = 3'd0;
      len_d      = '0;
      byte_idx_d = '0;
      csum_d     = 8'h00;
      asm_cnt_d  = '0;
      timer_d    = '0;
      addr_d     = BASE_ADDR;
      finish_d   = 1'b0;
      err_d      = 1'b0;
      wcount_d   = '0;
    end else begin
      // Write bookkeeping trails the strobe by one cycle so uart_addr_o is
      // still the address of the word being written while uart_we_o is high.
      if (we_q) begin
        wcount_d = wcount_q + 32'd1;
        addr_d   = addr_q + c_STEP;
      end

      if (rx_valid_i) begin
        timer_d = '0;
      end else if (w_timer_run) begin
        timer_d = timer_q + 32'd1;
      end

      case (state_q)
        c_ST_HDR: begin
          if (rx_valid_i) begin
            len_d     = w_new_len;
            hdr_cnt_d = hdr_cnt_q + 3'd1;
            if (hdr_cnt_q == 3'd3) begin
              hdr_cnt_d  = 3'd0;
              byte_idx_d = '0;
              csum_d     = 8'h00;
              asm_cnt_d  = '0;
              wcount_d   = '0;
              if ((w_new_len == 32'd0) || (w_new_len > c_MAX_WORDS)) begin
                state_d = c_ST_ERR;
                err_d   = 1'b1;
              end else begin
                state_d = c_ST_PAYLOAD;
              end
            end
          end
        end

        c_ST_PAYLOAD: begin
          if (rx_valid_i) begin
            buf_d  = w_word;
            csum_d = csum_q ^ rx_byte_i;
            if (w_last_byte) begin
              byte_idx_d = '0;
              data_d     = w_word;
              we_d       = 1'b1;
              asm_cnt_d  = asm_cnt_q + 32'd1;
              if (w_last_word) begin
                state_d = (CHECKSUM_EN != 0) ? c_ST_CSUM : c_ST_DONE;
              end
            end else begin
              byte_idx_d = byte_idx_q + c_IDXW'(1);
            end
          end
        end

        c_ST_CSUM: begin
          if (rx_valid_i) begin
            if (rx_byte_i == csum_q) begin
              state_d  = c_ST_DONE;
              finish_d = 1'b1;
            end else begin
              state_d = c_ST_ERR;
              err_d   = 1'b1;
            end
          end
        end

        // Without a checksum, finish follows the last write strobe by one
        // cycle because it is raised from the DONE state itself.
        c_ST_DONE: begin
          finish_d = 1'b1;
        end

        c_ST_ERR: begin
          err_d    = 1'b1;
          finish_d = 1'b0;
        end

        default: begin
          state_d = c_ST_ERR;
          err_d   = 1'b1;
        end
      endcase

      if (w_timeout) begin
        state_d  = c_ST_ERR;
        err_d    = 1'b1;
        finish_d = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= c_ST_HDR;
      hdr_cnt_q  <= 3'd0;
      len_q      <= '0;
      byte_idx_q <= '0;
      buf_q      <= '0;
      csum_q     <= 8'h00;
      asm_cnt_q  <= '0;
      timer_q    <= '0;
      data_q     <= '0;
      addr_q     <= BASE_ADDR;
      we_q       <= 1'b0;
      finish_q   <= 1'b0;
      err_q      <= 1'b0;
      wcount_q   <= '0;
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      buf_q      <= buf_d;
      csum_q     <= csum_d;
      asm_cnt_q  <= asm_cnt_d;
      timer_q    <= timer_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      finish_q   <= finish_d;
      err_q      <= err_d;
      wcount_q   <= wcount_d;
    end
  end

  assign uart_data_o   = data_q;
  assign uart_addr_o   = addr_q;
  assign uart_we_o     = we_q;
  assign uart_finish_o = finish_q;
  assign load_error_o  = err_q;
  assign word_count_o  = wcount_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_prog_loader
// Purpose  : Self-checking bench for uart_prog_loader. Two instances:
//            A = 32-bit words, checksum on, TIMEOUT 10, MAX_WORDS 16;
//            B = 16-bit words at 0x100 step 2, no checksum, no timeout.
//            Frames and expected writes come from a byte-level frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_prog_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A
  logic        rst_a, rxv_a, start_a;
  logic [7:0]  rxb_a;
  logic [31:0] data_a, addr_a, wc_a;
  logic        we_a, fin_a, err_a;

  // Instance B
  logic        rst_b, rxv_b, start_b;
  logic [7:0]  rxb_b;
  logic [15:0] data_b;
  logic [31:0] addr_b, wc_b;
  logic        we_b, fin_b, err_b;

  uart_prog_loader #(
    .DATA_W(32), .ADDR_W(32), .BASE_ADDR(32'h0), .ADDR_STEP(4),
    .MAX_WORDS(16), .CHECKSUM_EN(1), .TIMEOUT(10)
  ) u_dut_a (
    .clk(clk), .rst(rst_a), .rx_valid_i(rxv_a), .rx_byte_i(rxb_a),
    .start_i(start_a), .uart_data_o(data_a), .uart_addr_o(addr_a),
    .uart_we_o(we_a), .uart_finish_o(fin_a), .load_error_o(err_a),
    .word_count_o(wc_a)
  );

  uart_prog_loader #(
    .DATA_W(16), .ADDR_W(32), .BASE_ADDR(32'h100), .ADDR_STEP(2),
    .MAX_WORDS(16), .CHECKSUM_EN(0), .TIMEOUT(0)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .rx_valid_i(rxv_b), .rx_byte_i(rxb_b),
    .start_i(start_b), .uart_data_o(data_b), .uart_addr_o(addr_b),
    .uart_we_o(we_b), .uart_finish_o(fin_b), .load_error_o(err_b),
    .word_count_o(wc_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [63:0] addr; logic [63:0] data; } wr_t;
  typedef wr_t wr_q_t[$];

  wr_t         got_a[$];
  wr_t         got_b[$];
  wr_t         exp_q[$];
  logic [7:0]  frame_q[$];
  logic [63:0] words_q[$];

  // Write monitors
  always @(negedge clk) begin
    wr_t w;
    if (we_a === 1'b1) begin
      w.addr = 64'(addr_a); w.data = 64'(data_a); got_a.push_back(w);
    end
    if (we_b === 1'b1) begin
      w.addr = 64'(addr_b); w.data = 64'(data_b); got_b.push_back(w);
    end
  end

  // Frame model: header, payload LSB-first, optional XOR checksum (^delta
  // to corrupt it). Expected writes exist only for a legal header.
  task automatic make_frame(input logic [31:0] n_hdr, input int bpw, input logic [31:0] base,
                            input int step, input bit csum_en, input logic [7:0] delta,
                            input int max_words);
    logic [7:0]  x;
    logic [63:0] w;
    wr_t         e;
    frame_q.delete();
    exp_q.delete();
    x = 8'h00;
    for (int b = 0; b < 4; b++) frame_q.push_back(n_hdr[8*b +: 8]);
    if (n_hdr >= 1 && n_hdr <= 32'(max_words)) begin
      for (int i = 0; i < int'(n_hdr); i++) begin
        w = words_q[i];
        for (int b = 0; b < bpw; b++) begin
          frame_q.push_back(w[8*b +: 8]);
          x = x ^ w[8*b +: 8];
        end
        e.addr = 64'(base + 32'(i * step));
        e.data = w;
        exp_q.push_back(e);
      end
      if (csum_en) frame_q.push_back(x ^ delta);
    end
  endtask

  task automatic cmp_writes(input string tag, input wr_q_t got);
    check({tag, " write count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check($sformatf("%s addr[%0d]", tag, i), got[i].addr, exp_q[i].addr);
      check($sformatf("%s data[%0d]", tag, i), got[i].data, exp_q[i].data);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Sends frame_q[lo..hi-1] to instance inst with 0..max_gap idle cycles before each byte.
  task automatic send(input bit inst, input int lo, input int hi, input int max_gap);
    for (int i = lo; i < hi; i++) begin
      idle(int'($urandom_range(0, max_gap)));
      if (!inst) begin rxv_a = 1'b1; rxb_a = frame_q[i]; end
      else       begin rxv_b = 1'b1; rxb_b = frame_q[i]; end
      @(posedge clk); #1;
      rxv_a = 1'b0; rxv_b = 1'b0;
    end
  endtask

  task automatic do_start(input bit inst);
    if (!inst) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] n;
    bit          bad;
    int          sz;
    rst_a = 1'b1; rst_b = 1'b1;
    rxv_a = 1'b0; rxv_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    rxb_a = 8'h00; rxb_b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset A data",   64'(data_a), 64'h0);
    check("reset A addr",   64'(addr_a), 64'h0);
    check("reset A we",     64'(we_a),   64'h0);
    check("reset A finish", 64'(fin_a),  64'h0);
    check("reset A error",  64'(err_a),  64'h0);
    check("reset A wcount", 64'(wc_a),   64'h0);
    check("reset B addr",   64'(addr_b), 64'h100);
    rst_a = 1'b0; rst_b = 1'b0;
    idle(2);

    // Directed good frame, N=2
    words_q = '{64'h44332211, 64'hDDCCBBAA};
    make_frame(32'd2, 4, 32'h0, 4, 1'b1, 8'h00, 16);
    got_a.delete();
    send(1'b0, 0, frame_q.size() - 1, 0);
    check("good frame finish before csum", 64'(fin_a), 64'h0);
    send(1'b0, frame_q.size() - 1, frame_q.size(), 0);
    check("good frame finish after csum", 64'(fin_a), 64'h1);
    check("good frame error", 64'(err_a), 64'h0);
    check("good frame wcount", 64'(wc_a), 64'h2);
    idle(2);
    cmp_writes("good frame", got_a);

    // Same frame, corrupted checksum
    do_start(1'b0);
    check("start clears finish", 64'(fin_a), 64'h0);
    check("start clears wcount", 64'(wc_a), 64'h0);
    make_frame(32'd2, 4, 32'h0, 4, 1'b1, 8'h01, 16);
    got_a.delete();
    send(1'b0, 0, frame_q.size(), 1);
    check("bad csum error", 64'(err_a), 64'h1);
    check("bad csum finish", 64'(fin_a), 64'h0);
    idle(2);
    cmp_writes("bad csum", got_a);

    // Illegal headers: N=0 and N=MAX_WORDS+1
    foreach (words_q[i]) words_q[i] = 64'h0;
    for (int t = 0; t < 2; t++) begin
      do_start(1'b0);
      got_a.delete();
      make_frame((t == 0) ? 32'd0 : 32'd17, 4, 32'h0, 4, 1'b1, 8'h00, 16);
      send(1'b0, 0, 4, 0);
      check($sformatf("bad header %0d error", t), 64'(err_a), 64'h1);
      frame_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      send(1'b0, 0, 5, 0);
      idle(2);
      check($sformatf("bad header %0d no writes", t), 64'(got_a.size()), 64'h0);
      check($sformatf("bad header %0d error held", t), 64'(err_a), 64'h1);
    end

    // Inter-byte timeout after header + 2 payload bytes
    do_start(1'b0);
    words_q = '{64'h12345678, 64'h9ABCDEF0};
    make_frame(32'd2, 4, 32'h0, 4, 1'b1, 8'h00, 16);
    send(1'b0, 0, 6, 0);
    idle(9);
    check("timeout not early", 64'(err_a), 64'h0);
    idle(1);
    check("timeout expired", 64'(err_a), 64'h1);
    do_start(1'b0);
    words_q = '{64'(32'hCAFEF00D)};
    make_frame(32'd1, 4, 32'h0, 4, 1'b1, 8'h00, 16);
    got_a.delete();
    send(1'b0, 0, frame_q.size(), 2);
    idle(2);
    check("after timeout finish", 64'(fin_a), 64'h1);
    check("after timeout wcount", 64'(wc_a), 64'h1);
    cmp_writes("after timeout", got_a);

    // start coincident with a payload byte: byte dropped, fresh header follows
    do_start(1'b0);
    words_q = '{64'h11111111, 64'h22222222};
    make_frame(32'd2, 4, 32'h0, 4, 1'b1, 8'h00, 16);
    got_a.delete();
    send(1'b0, 0, 7, 0);
    start_a = 1'b1; rxv_a = 1'b1; rxb_a = 8'h5A;
    @(posedge clk); #1;
    start_a = 1'b0; rxv_a = 1'b0;
    words_q = '{64'(32'h0BADBEEF)};
    make_frame(32'd1, 4, 32'h0, 4, 1'b1, 8'h00, 16);
    send(1'b0, 0, frame_q.size(), 0);
    check("restart finish", 64'(fin_a), 64'h1);
    idle(2);
    check("restart wcount", 64'(wc_a), 64'h1);
    cmp_writes("restart", got_a);

    // Bytes after DONE are ignored
    frame_q = '{8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send(1'b0, 0, 6, 0);
    idle(2);
    check("done ignores bytes writes", 64'(got_a.size()), 64'h1);
    check("done ignores bytes finish", 64'(fin_a), 64'h1);
    check("done ignores bytes wcount", 64'(wc_a), 64'h1);

    // Randomised frames
    for (int it = 0; it < 25; it++) begin
      do_start(1'b0);
      got_a.delete();
      words_q.delete();
      if ($urandom_range(0, 7) == 0) begin
        n = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(17, 300));
        make_frame(n, 4, 32'h0, 4, 1'b1, 8'h00, 16);
        send(1'b0, 0, frame_q.size(), 3);
        idle(2);
        check($sformatf("rand %0d illegal error", it), 64'(err_a), 64'h1);
        check($sformatf("rand %0d illegal wcount", it), 64'(wc_a), 64'h0);
        cmp_writes($sformatf("rand %0d", it), got_a);
      end else begin
        n   = 32'($urandom_range(1, 5));
        bad = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < int'(n); i++) words_q.push_back(64'($urandom));
        make_frame(n, 4, 32'h0, 4, 1'b1, bad ? 8'($urandom_range(1, 255)) : 8'h00, 16);
        send(1'b0, 0, frame_q.size(), 3);
        idle(2);
        check($sformatf("rand %0d finish", it), 64'(fin_a), 64'(!bad));
        check($sformatf("rand %0d error", it), 64'(err_a), 64'(bad));
        check($sformatf("rand %0d wcount", it), 64'(wc_a), 64'(n));
        cmp_writes($sformatf("rand %0d", it), got_a);
      end
    end

    // Instance B: 16-bit words, back-to-back bytes, no checksum
    words_q = '{64'($urandom_range(0, 65535)), 64'($urandom_range(0, 65535)),
                64'($urandom_range(0, 65535))};
    make_frame(32'd3, 2, 32'h100, 2, 1'b0, 8'h00, 16);
    got_b.delete();
    send(1'b1, 0, frame_q.size(), 0);
    check("B final strobe", 64'(we_b), 64'h1);
    check("B finish not yet", 64'(fin_b), 64'h0);
    idle(1);
    check("B finish after strobe", 64'(fin_b), 64'h1);
    check("B wcount", 64'(wc_b), 64'h3);
    cmp_writes("B frame", got_b);

    // Instance B: reset asserted after the 2nd write
    do_start(1'b1);
    words_q = '{64'h0A0B, 64'h0C0D, 64'h0E0F};
    make_frame(32'd3, 2, 32'h100, 2, 1'b0, 8'h00, 16);
    got_b.delete();
    send(1'b1, 0, 8, 0);
    idle(1);
    sz = got_b.size();
    check("B writes before reset", 64'(sz), 64'h2);
    #2 rst_b = 1'b1;
    #1;
    check("B reset data",   64'(data_b), 64'h0);
    check("B reset addr",   64'(addr_b), 64'h100);
    check("B reset we",     64'(we_b),   64'h0);
    check("B reset finish", 64'(fin_b),  64'h0);
    check("B reset error",  64'(err_b),  64'h0);
    check("B reset wcount", 64'(wc_b),   64'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_b = 1'b0;
    send(1'b1, 8, frame_q.size(), 0);
    idle(3);
    check("B no writes after reset", 64'(got_b.size()), 64'(sz));
    check("B finish stays low", 64'(fin_b), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
